// File: rtl/preg_release_queue_if.sv
// Commit-side and freelist-side signal bundle for preg_release_queue.
// The queue sits on the slave modport; the commit/ROB side is the master.
`ifndef ROB_STATE_IDLE
`define ROB_STATE_IDLE     2'd0
`endif
`ifndef ROB_STATE_ROLLBACK
`define ROB_STATE_ROLLBACK 2'd1
`endif
`ifndef ROB_STATE_WALK
`define ROB_STATE_WALK     2'd2
`endif

interface preg_release_queue_if #(
  parameter int DEPTH  = 8,
  parameter int PREG_W = 6
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              commit0_valid;
  logic              commit0_has_dest;
  logic [PREG_W-1:0] commit0_old_preg;
  logic              commit1_valid;
  logic              commit1_has_dest;
  logic [PREG_W-1:0] commit1_old_preg;
  logic              commit_ready;
  logic [1:0]        rob_state;
  logic              write0_valid;
  logic [PREG_W-1:0] write0_data;
  logic              write1_valid;
  logic [PREG_W-1:0] write1_data;
  logic [CNT_W-1:0]  count;
  logic              overflow_err;

  modport master (
    output commit0_valid, commit0_has_dest, commit0_old_preg,
    output commit1_valid, commit1_has_dest, commit1_old_preg,
    output rob_state,
    input  commit_ready, write0_valid, write0_data, write1_valid, write1_data,
    input  count, overflow_err
  );

  modport slave (
    input  commit0_valid, commit0_has_dest, commit0_old_preg,
    input  commit1_valid, commit1_has_dest, commit1_old_preg,
    input  rob_state,
    output commit_ready, write0_valid, write0_data, write1_valid, write1_data,
    output count, overflow_err
  );
endinterface

// File: rtl/preg_release_queue.sv
// Buffers old physical registers of committing instructions and drains them two per
// cycle into the freelist free ports while the ROB is IDLE. Option: RELEASE_BYPASS_EN.
`ifndef ROB_STATE_IDLE
`define ROB_STATE_IDLE     2'd0
`endif

module preg_release_queue #(
  parameter int DEPTH  = 8,
  parameter int PREG_W = 6
) (
  input logic            clock,
  input logic            reset_n,
  preg_release_queue_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef logic [CNT_W-1:0] ptr_t;
  typedef logic [IDX_W-1:0] idx_t;

  ptr_t              enq_ptr, deq_ptr, occ;
  idx_t              enq_idx, enq_idx1, deq_idx, deq_idx1;
  logic [PREG_W-1:0] mem [DEPTH];

  logic              idle, empty, ready, byp;
  logic              q0, q1, push0, push1, pop0, pop1, ovf_hit;
  logic [PREG_W-1:0] first_preg;

  logic              wr0_vld_p1, wr1_vld_p1, ovf_q;
  logic [PREG_W-1:0] wr0_data_p1, wr1_data_p1;

  // Occupancy is the pointer distance; the extra MSB keeps full and empty distinct.
  assign occ      = enq_ptr - deq_ptr;
  assign empty    = (enq_ptr == deq_ptr);
  assign ready    = (occ <= ptr_t'(DEPTH - 2));
  assign enq_idx  = enq_ptr[IDX_W-1:0];
  assign enq_idx1 = enq_idx + 1'b1;
  assign deq_idx  = deq_ptr[IDX_W-1:0];
  assign deq_idx1 = deq_idx + 1'b1;

  assign idle = (bus.rob_state == `ROB_STATE_IDLE);
  assign q0   = bus.commit0_valid & bus.commit0_has_dest;
  assign q1   = bus.commit1_valid & bus.commit1_has_dest;

  // Compaction: a lone slot-1 entry takes the first free position.
  assign first_preg = q0 ? bus.commit0_old_preg : bus.commit1_old_preg;

`ifdef RELEASE_BYPASS_EN
  assign byp = idle & empty;
`else
  assign byp = 1'b0;
`endif

  assign push0   = ready & ~byp & (q0 | q1);
  assign push1   = ready & ~byp & q0 & q1;
  assign ovf_hit = ~ready & ~byp & (q0 | q1);

  // Pops only see pre-edge contents, so a simultaneous push never feeds a pop.
  assign pop0 = idle & ~empty;
  assign pop1 = idle & (occ >= ptr_t'(2));

  always_ff @(posedge clock) begin
    if (push0) mem[enq_idx]  <= first_preg;
    if (push1) mem[enq_idx1] <= bus.commit1_old_preg;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enq_ptr <= '0;
      deq_ptr <= '0;
      ovf_q   <= 1'b0;
    end else begin
      enq_ptr <= enq_ptr + ptr_t'(push0) + ptr_t'(push1);
      deq_ptr <= deq_ptr + ptr_t'(pop0) + ptr_t'(pop1);
      if (ovf_hit) ovf_q <= 1'b1;
    end
  end

  // Stage p1: registered free ports; data holds when nothing is released.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr0_vld_p1  <= 1'b0;
      wr1_vld_p1  <= 1'b0;
      wr0_data_p1 <= '0;
      wr1_data_p1 <= '0;
    end else begin
      wr0_vld_p1 <= 1'b0;
      wr1_vld_p1 <= 1'b0;
      if (pop0) begin
        wr0_vld_p1  <= 1'b1;
        wr0_data_p1 <= mem[deq_idx];
      end else if (byp & (q0 | q1)) begin
        wr0_vld_p1  <= 1'b1;
        wr0_data_p1 <= first_preg;
      end
      if (pop1) begin
        wr1_vld_p1  <= 1'b1;
        wr1_data_p1 <= mem[deq_idx1];
      end else if (byp & q0 & q1) begin
        wr1_vld_p1  <= 1'b1;
        wr1_data_p1 <= bus.commit1_old_preg;
      end
    end
  end

  assign bus.commit_ready = ready;
  assign bus.count        = occ;
  assign bus.overflow_err = ovf_q;
  assign bus.write0_valid = wr0_vld_p1;
  assign bus.write0_data  = wr0_data_p1;
  assign bus.write1_valid = wr1_vld_p1;
  assign bus.write1_data  = wr1_data_p1;

endmodule
